// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer : issue/hold/commit controller for the shared 32-bit divider
//                 and owner of HI/LO. Optional macro: DIV_ZERO_TRAP_EN.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_sequencer #(
  parameter int LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic        div_zero
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_sign_q, div_sign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_q, div_zero_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_sign_d = div_sign_q;
    hi_d       = hilo_wdata;
    lo_d       = hilo_wdata;
    done_d     = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    div_zero_d = 1'b0;
`endif
    if (!hi_we) hi_d = hi_q;
    if (!lo_we) lo_d = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          div_a_d    = dividend;
          div_b_d    = divisor;
          div_sign_d = sign;
`ifdef DIV_ZERO_TRAP_EN
          if (divisor == 32'd0) begin
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_INIT;
          end
`else
          state_d = ST_RUN;
          cnt_d   = CNT_INIT;
`endif
        end
      end
      ST_RUN: begin
        // A flush aborts the divide even on the commit cycle.
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          hi_d    = div_r;
          lo_d    = div_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      div_a_q    <= 32'd0;
      div_b_q    <= 32'd0;
      div_sign_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_sign_q <= div_sign_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign div_sign = div_sign_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = div_zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, corner sequences, and a
// randomized run against a cycle-count based model of HI/LO/busy/done.
`default_nettype none

module tb_div_sequencer;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, sign, cancel, hi_we, lo_we;
  logic [31:0] dividend, divisor, hilo_wdata;
  logic [31:0] div_a, div_b, div_q, div_r, hi, lo;
  logic        div_sign, busy, done;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  int checks = 0;
  int failures = 0;

  div_sequencer #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
    .div_a(div_a), .div_b(div_b), .div_sign(div_sign),
    .div_q(div_q), .div_r(div_r), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
`ifdef DIV_ZERO_TRAP_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  // Divider stand-in; returns {remainder, quotient}. x/0 gives q=all-ones, r=x.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign {div_r, div_q} = ref_div(div_sign, div_a, div_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Issue a divide now; returns in the done cycle (cycle LAT+1).
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input string tag);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      chk($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s done c%0d", tag, k), {31'd0, done}, 32'd0);
      tick();
    end
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " lo"}, lo, q);
    chk({tag, " hi"}, hi, r);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[6];

  // Model state for the random phase
  bit          m_inflight;
  longint      m_due;
  logic        m_s;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_done;
  logic        m_dz;

  initial begin
    logic [31:0] save_hi, save_lo;
    logic [63:0] rq;
    longint      edge_n;
    bit          commit;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd9,          32'd4,          32'd2,          32'd1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};

    idle_inputs();
    sign = 1'b0; dividend = 32'd0; divisor = 32'd0; hilo_wdata = 32'd0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst div_a", div_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back: each vector is issued in the previous one's done cycle
    for (int i = 0; i < 6; i++)
      run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
    tick();
    chk("after vec done low", {31'd0, done}, 32'd0);
    save_hi = hi; save_lo = lo;

    // Cancel in cycle 4
    sign = 1'b0; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    cancel = 1'b1;
    tick(); cancel = 1'b0;
    chk("cancel busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      chk("cancel done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("cancel hi", hi, save_hi);
    chk("cancel lo", lo, save_lo);

    // Cancel on the commit cycle
    dividend = 32'd60; divisor = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    chk("cc busy at L", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick(); cancel = 1'b0;
    chk("cc busy", {31'd0, busy}, 32'd0);
    chk("cc done", {31'd0, done}, 32'd0);
    chk("cc hi", hi, save_hi);
    chk("cc lo", lo, save_lo);

    // Start with cancel in idle is not accepted
    start = 1'b1; cancel = 1'b1;
    tick(); idle_inputs();
    chk("sc busy", {31'd0, busy}, 32'd0);

    // Starts while busy ignored; MTLO on the commit edge loses
    sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    dividend = 32'd77; divisor = 32'd5;
    for (int k = 1; k <= LAT; k++) begin
      chk($sformatf("sb busy c%0d", k), {31'd0, busy}, 32'd1);
      if (k == LAT) begin lo_we = 1'b1; hilo_wdata = 32'd5; end
      tick();
    end
    idle_inputs();
    chk("sb done", {31'd0, done}, 32'd1);
    chk("sb lo", lo, 32'd333);
    chk("sb hi", hi, 32'd1);
    tick();
    chk("sb busy after", {31'd0, busy}, 32'd0);
    chk("sb done after", {31'd0, done}, 32'd0);

    // MTHI / MTLO in idle
    hi_we = 1'b1; hilo_wdata = 32'hCAFE_F00D;
    tick(); hi_we = 1'b0;
    chk("mthi hi", hi, 32'hCAFE_F00D);
    chk("mthi lo", lo, 32'd333);
    lo_we = 1'b1; hilo_wdata = 32'h1234_5678;
    tick(); lo_we = 1'b0;
    chk("mtlo lo", lo, 32'h1234_5678);
    chk("mtlo hi", hi, 32'hCAFE_F00D);

    // Divisor zero
`ifdef DIV_ZERO_TRAP_EN
    sign = 1'b0; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("dz pulse", {31'd0, div_zero}, 32'd1);
    chk("dz busy", {31'd0, busy}, 32'd0);
    chk("dz done", {31'd0, done}, 32'd0);
    tick();
    chk("dz pulse end", {31'd0, div_zero}, 32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      chk("dz no done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("dz hi", hi, 32'hCAFE_F00D);
    chk("dz lo", lo, 32'h1234_5678);
`else
    run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "div0");
    tick();
`endif

    // Reset in the middle of a divide
    sign = 1'b0; dividend = 32'd99; divisor = 32'd9; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst hi", hi, 32'd0);
    chk("mrst lo", lo, 32'd0);
    chk("mrst div_b", div_b, 32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      chk("mrst done", {31'd0, done}, 32'd0);
      tick();
    end

    // Randomized run: a divide accepted on edge e commits on edge e+LAT
    m_inflight = 0; m_due = 0; m_hi = 32'd0; m_lo = 32'd0;
    m_s = 1'b0; m_a = 32'd0; m_b = 32'd0;
    edge_n = 0;
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(0, 9) < 3);
      cancel     = ($urandom_range(0, 39) == 0);
      hi_we      = ($urandom_range(0, 9) == 0);
      lo_we      = ($urandom_range(0, 9) == 0);
      hilo_wdata = $urandom;
      sign       = $urandom_range(0, 1);
      dividend   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
      divisor    = ($urandom_range(0, 7) == 0) ? 32'd0 :
                   (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));

      edge_n++;
      commit = m_inflight && (edge_n == m_due) && !cancel;
      m_done = commit;
      m_dz   = 1'b0;
      if (!commit) begin
        if (hi_we) m_hi = hilo_wdata;
        if (lo_we) m_lo = hilo_wdata;
      end
      if (m_inflight) begin
        if (cancel || commit) m_inflight = 0;
        if (commit) begin
          rq = ref_div(m_s, m_a, m_b);
          m_hi = rq[63:32];
          m_lo = rq[31:0];
        end
      end else if (start && !cancel) begin
`ifdef DIV_ZERO_TRAP_EN
        if (divisor == 32'd0) m_dz = 1'b1;
        else begin
          m_inflight = 1; m_due = edge_n + LAT;
        end
`else
        m_inflight = 1; m_due = edge_n + LAT;
`endif
        m_s = sign; m_a = dividend; m_b = divisor;
      end

      tick();
      chk($sformatf("rnd%0d busy", n), {31'd0, busy}, {31'd0, m_inflight});
      chk($sformatf("rnd%0d done", n), {31'd0, done}, {31'd0, m_done});
      chk($sformatf("rnd%0d hi", n), hi, m_hi);
      chk($sformatf("rnd%0d lo", n), lo, m_lo);
`ifdef DIV_ZERO_TRAP_EN
      chk($sformatf("rnd%0d div_zero", n), {31'd0, div_zero}, {31'd0, m_dz});
`endif
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
